flash_block_sequencer: RTL
==========================

Name: flash_block_sequencer

Overview:
- Sits directly upstream of the Flash byte-access controller; drives its addr/data/direction_rw/fb_start inputs and consumes fb_done plus read data.
- Saves NUM_BYTES bytes of scoreboard state to flash, or restores them, as one multi-byte transaction.
- State is read from and written back to the score register file through a simple indexed byte port.
- Optional read-back verify on save; per-byte timeout protects against a stuck controller.

Parameters:
- BASE_ADDR, 8'h00, first flash byte address used.
- NUM_BYTES, 16, bytes per transaction, 1..2^IDX_W.
- IDX_W, 4, width of the register-file index.
- VERIFY, 1, 1 = after each byte write, read it back and compare.
- TIMEOUT_CYCLES, 50000, max cycles per handshake phase (1 ms at 50 MHz).

Ports:
- CLK_50MHZ  in  1  system clock, 50 MHz.
- RST  in  1  asynchronous, active-low reset.
- save_req  in  1  single-cycle pulse; start save.
- load_req  in  1  single-cycle pulse; start load.
- busy  out  1  high from accepted request until done.
- done  out  1  one-cycle pulse at end of transaction, success or error.
- err_code  out  2  00 ok, 01 timeout, 10 verify mismatch; held until next accepted request.
- src_idx  out  IDX_W  register-file read index.
- src_data  in  8  register-file byte; combinational from src_idx.
- dst_we  out  1  one-cycle register-file write strobe (load only).
- dst_idx  out  IDX_W  register-file write index.
- dst_data  out  8  register-file write data.
- addr  out  8  to Flash: byte address.
- data  out  8  to Flash: write data.
- direction_rw  out  1  to Flash: 0 write, 1 read.
- fb_start  out  1  to Flash: operation request, level.
- fb_done  in  1  from Flash: operation complete, level.
- fb_rdata  in  8  from Flash: read data, valid while fb_done=1 on a read.

Behaviour:
- Reset (RST=0, asynchronous): state IDLE; every output 0, including busy, done, err_code, fb_start, dst_we, all buses and idx. fb_start drops immediately, mid-operation included. No resume after reset.
- Requests accepted only in IDLE. save_req and load_req in the same cycle: save wins. Requests while busy are ignored.
- On accept: idx=0, err_code=00, busy=1.
- Address: addr = BASE_ADDR + idx, 8-bit, wraps modulo 256 (BASE_ADDR=8'hF8 with 16 bytes uses F8..FF, 00..07).
- Flash handshake, one op:
  - ISSUE: addr/data/direction_rw stable, fb_start=1 held until fb_done sampled 1.
  - RELEASE: fb_start=0, wait until fb_done sampled 0.
  - addr/data/direction_rw are unchanged from ISSUE entry to RELEASE exit.
- Save flow per byte:
  - FETCH (1 cycle): src_idx=idx.
  - LATCH: data<=src_data, direction_rw=0.
  - ISSUE_W, RELEASE_W.
  - If VERIFY: ISSUE_R with direction_rw=1; capture fb_rdata in the cycle fb_done is first seen 1; RELEASE_R; mismatch against the latched byte -> err 10, go FINISH.
  - NEXT.
- Load flow per byte: ISSUE_R, capture, RELEASE_R; then one cycle with dst_we=1, dst_idx=idx, dst_data=captured byte; NEXT.
- NEXT: if idx==NUM_BYTES-1 go FINISH, else idx+1 and repeat the per-byte flow.
- Timeout: a counter clears on entry to each ISSUE/RELEASE state. Reaching TIMEOUT_CYCLES while waiting: fb_start=0, err 01, FINISH. The next request is still gated on fb_done=0 via an initial RELEASE-style wait before ISSUE.
- FINISH: done=1 for one cycle, busy=0 on the same edge, return to IDLE.
- Error aborts the transaction; remaining bytes are untouched (no dst_we for them).
- No fb_start rising edge ever occurs while fb_done=1.

Test Plan:
- Reset, fill the register file with 8'h10+i, BASE_ADDR=8'h35, save_req with a Flash model answering fb_done after 5 cycles -> 16 writes to 8'h35..8'h44, data 8'h10..8'h1F, 16 verify reads, done pulse, err_code=00, busy low after done.
- Load with the model preloaded with 8'hC9 at every address -> 16 dst_we pulses, dst_idx 0..15, dst_data 8'hC9, err_code=00.
- Model corrupts the read-back of byte 3 (returns 8'h00 instead of 8'h13) -> err_code=10 after byte 3, done pulse, no write issued to 8'h39.
- Model never raises fb_done, TIMEOUT_CYCLES=100 -> fb_start high exactly 100 cycles then low, err_code=01, done pulse.
- save_req and load_req in the same cycle -> save runs (direction_rw=0 first op); load_req pulsed mid-save is ignored.
- BASE_ADDR=8'hF8, save -> addresses wrap F8..FF, 00..07. Assert RST low during byte 5 -> fb_start, busy, dst_we drop asynchronously; after release the block idles until a new request.

Source files
------------

// File: rtl/flash_block_sequencer.sv
// flash_block_sequencer
//   Saves or restores NUM_BYTES bytes of score-register-file state to/from flash
//   as one transaction, driving the flash byte-access controller through a
//   level start/done handshake.  Saves can optionally read each byte back and
//   compare it.  Every handshake wait is bounded by TIMEOUT_CYCLES.
//
// Ports
//   CLK_50MHZ, RST           clock, asynchronous active-low reset
//   save_req, load_req       single-cycle request pulses (save wins on collision)
//   busy, done, err_code     status: busy level, done pulse, 00 ok/01 timeout/10 verify
//   src_idx, src_data        register-file read port (combinational data)
//   dst_we, dst_idx, dst_data register-file write port (load only)
//   addr, data, direction_rw, fb_start  to flash controller (0 write, 1 read)
//   fb_done, fb_rdata        from flash controller
module flash_block_sequencer #(
  parameter logic [7:0]  BASE_ADDR      = 8'h00,
  parameter int unsigned NUM_BYTES      = 16,
  parameter int unsigned IDX_W          = 4,
  parameter bit          VERIFY         = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic             CLK_50MHZ,
  input  logic             RST,
  input  logic             save_req,
  input  logic             load_req,
  output logic             busy,
  output logic             done,
  output logic [1:0]       err_code,
  output logic [IDX_W-1:0] src_idx,
  input  logic [7:0]       src_data,
  output logic             dst_we,
  output logic [IDX_W-1:0] dst_idx,
  output logic [7:0]       dst_data,
  output logic [7:0]       addr,
  output logic [7:0]       data,
  output logic             direction_rw,
  output logic             fb_start,
  input  logic             fb_done,
  input  logic [7:0]       fb_rdata
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [3:0] {
    StIdle, StPre, StFetch, StLatch, StIssueW, StReleaseW, StRdSetup,
    StIssueR, StReleaseR, StDstWr, StNext, StFinish
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             save_q, save_d;
  logic [1:0]       err_q, err_d;
  logic [7:0]       addr_q, addr_d;
  logic [7:0]       data_q, data_d;
  logic             dir_q, dir_d;
  logic [7:0]       rdata_q, rdata_d;

  logic             waiting;
  logic             timed_out;
  logic [7:0]       byte_addr;

  // Address arithmetic is 8-bit on purpose so the window wraps modulo 256.
  assign byte_addr = BASE_ADDR + 8'(idx_q);
  assign timed_out = (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    save_d  = save_q;
    err_d   = err_q;
    addr_d  = addr_q;
    data_d  = data_q;
    dir_d   = dir_q;
    rdata_d = rdata_q;
    waiting = 1'b0;

    case (state_q)
      StIdle: begin
        if (save_req || load_req) begin
          save_d  = save_req;
          idx_d   = '0;
          err_d   = 2'b00;
          state_d = StPre;
        end
      end
      // Controller may still be finishing an op abandoned by a timeout.
      StPre: begin
        waiting = 1'b1;
        if (!fb_done) begin
          state_d = save_q ? StFetch : StRdSetup;
        end else if (timed_out) begin
          err_d   = 2'b01;
          state_d = StFinish;
        end
      end
      StFetch: state_d = StLatch;
      StLatch: begin
        data_d  = src_data;
        addr_d  = byte_addr;
        dir_d   = 1'b0;
        state_d = StIssueW;
      end
      StIssueW: begin
        waiting = 1'b1;
        if (fb_done) begin
          state_d = StReleaseW;
        end else if (timed_out) begin
          err_d   = 2'b01;
          state_d = StFinish;
        end
      end
      StReleaseW: begin
        waiting = 1'b1;
        if (!fb_done) begin
          if (VERIFY) begin
            dir_d   = 1'b1;
            state_d = StIssueR;
          end else begin
            state_d = StNext;
          end
        end else if (timed_out) begin
          err_d   = 2'b01;
          state_d = StFinish;
        end
      end
      StRdSetup: begin
        addr_d  = byte_addr;
        dir_d   = 1'b1;
        state_d = StIssueR;
      end
      StIssueR: begin
        waiting = 1'b1;
        if (fb_done) begin
          rdata_d = fb_rdata;
          state_d = StReleaseR;
        end else if (timed_out) begin
          err_d   = 2'b01;
          state_d = StFinish;
        end
      end
      StReleaseR: begin
        waiting = 1'b1;
        if (!fb_done) begin
          if (!save_q) begin
            state_d = StDstWr;
          end else if (rdata_q != data_q) begin
            err_d   = 2'b10;
            state_d = StFinish;
          end else begin
            state_d = StNext;
          end
        end else if (timed_out) begin
          err_d   = 2'b01;
          state_d = StFinish;
        end
      end
      StDstWr: state_d = StNext;
      StNext: begin
        if (idx_q == IDX_W'(NUM_BYTES - 1)) begin
          state_d = StFinish;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = save_q ? StFetch : StRdSetup;
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase

    // Counter restarts on every state change, so each wait phase gets its own budget.
    cnt_d = (waiting && (state_d == state_q)) ? cnt_q + CntW'(1) : '0;
  end

  always_ff @(posedge CLK_50MHZ or negedge RST) begin
    if (!RST) begin
      state_q <= StIdle;
      idx_q   <= '0;
      cnt_q   <= '0;
      save_q  <= 1'b0;
      err_q   <= 2'b00;
      addr_q  <= 8'h00;
      data_q  <= 8'h00;
      dir_q   <= 1'b0;
      rdata_q <= 8'h00;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      save_q  <= save_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      dir_q   <= dir_d;
      rdata_q <= rdata_d;
    end
  end

  // Decoded from state so reset removes fb_start and dst_we immediately.
  assign busy         = (state_q != StIdle) && (state_q != StFinish);
  assign done         = (state_q == StFinish);
  assign fb_start     = (state_q == StIssueW) || (state_q == StIssueR);
  assign dst_we       = (state_q == StDstWr);
  assign err_code     = err_q;
  assign src_idx      = idx_q;
  assign dst_idx      = idx_q;
  assign dst_data     = rdata_q;
  assign addr         = addr_q;
  assign data         = data_q;
  assign direction_rw = dir_q;

endmodule
